frame_buffer: RTL and testbench
===============================

# frame_buffer

Parametrised, writable pixel frame buffer for the VGA display path. Pixel coordinates (x, y) map row-major into a synchronous simple-dual-port memory. A registered read port serves the scan-out logic, and a write port serves the game/draw logic. A built-in clear engine fills the whole frame with one colour, so the game can wipe the screen without a full-frame software loop.

## Interface
- `WIDTH`, 160, pixels per row
- `HEIGHT`, 120, rows per frame
- `COLOR_BITS`, 3, bits per pixel
- `XW`, 8, x coordinate width; must satisfy 2^XW ≥ WIDTH
- `YW`, 7, y coordinate width; must satisfy 2^YW ≥ HEIGHT
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-high
- `rd_en` in 1: read request
- `rd_x` in XW, `rd_y` in YW: read coordinate
- `rd_data` out COLOR_BITS: pixel colour
- `rd_valid` out 1: rd_data valid
- `wr_en` in 1: write request
- `wr_x` in XW, `wr_y` in YW: write coordinate
- `wr_data` in COLOR_BITS: colour to write
- `wr_ready` out 1: write port accepts; equals !busy
- `clr_start` in 1: start full-frame clear
- `clr_color` in COLOR_BITS: fill colour, sampled on accepted clr_start
- `busy` out 1: clear in progress
- `done` out 1: one-cycle pulse at clear completion

## Operation
- Derived constants:
  - DEPTH = WIDTH*HEIGHT.
  - AW = clog2(DEPTH), which is 15 for the defaults.
  - Address = y*WIDTH + x, computed at AW bits with no truncation of intermediates.
- Read path:
  - Reads are always served, including while busy.
  - Read-during-write to the same address returns the old data (read-first).
  - A read while busy returns whatever the memory currently holds.
- Write path:
  - A write occurs when wr_en && wr_ready.
  - A write while busy is dropped. It is not queued.
- Clear FSM:
  - IDLE: clr_start latches clr_color and zeroes the address counter, then goes to CLEAR.
  - CLEAR: writes the latched colour to counter address, one per cycle, then increments the counter. After address DEPTH-1 is written, go to DONE. clr_start is ignored in this state.
  - DONE: done=1 for one cycle, then return to IDLE.
- Simultaneous wr_en and clr_start in IDLE:
  - The external write commits that cycle, since wr_ready is still 1.
  - The clear then overwrites it.
- Memory contents are not reset. There is no power-on initialisation beyond the clear engine.
- Reset mid-clear:
  - FSM returns to IDLE and the counter goes to 0.
  - Already-written pixels keep the fill colour; the rest are unchanged.
  - No done pulse is produced.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, done=0, wr_ready=1.
- Read latency is 1 cycle: rd_en at edge N gives rd_valid=1 and rd_data after edge N. rd_valid=0 otherwise.
- A write at edge N is visible to a read issued at edge N+1.
- busy rises the cycle after clr_start is accepted and stays high for exactly DEPTH cycles.
- done pulses the cycle after busy falls.
- A new clr_start is accepted in the cycle done is high, since the FSM returns to IDLE that same cycle.
- Total clear length is DEPTH+1 cycles from start to done (19201 for the defaults).

## Configuration
- `FRAME_BUFFER_BOUNDS_CHECK_EN`, defined:
  - A coordinate is out of range when x ≥ WIDTH or y ≥ HEIGHT.
  - Out-of-range writes are dropped. wr_ready is unaffected.
  - Out-of-range reads give rd_valid=1 and rd_data=0.
- Undefined:
  - No range check is performed.
  - Out-of-range behaviour is unspecified and not verified. Callers must stay in range.

## Structure
- Shared package `frame_buffer_pkg`:
  - Default WIDTH/HEIGHT/COLOR_BITS.
  - Colour constants (black=0, background=2).
  - The clear FSM state enum (IDLE, CLEAR, DONE).
- Sub-module `fb_ram`:
  - Simple dual-port RAM with DEPTH × COLOR_BITS entries, registered read, read-first.
  - No reset, so it infers block RAM.
  - The top level owns address arithmetic, write arbitration (clear engine vs external port), bounds check and rd_valid.

## Test plan
- Reset, then write (10,5)=5, then read (10,5) the next cycle → rd_valid=1 one cycle after rd_en, rd_data=5. Read (0,0) → 0 after a prior clear with colour 0.
- Write (159,119)=7, then read (159,119) → 7. Read (0,1) → unchanged, which confirms address = 1*160+0 with no aliasing.
- clr_start with clr_color=2 → busy high for exactly 19200 cycles and done pulses once. Every pixel then reads 2, with a sweep of all corners plus random samples.
- wr_en asserted while busy at (3,3) with data 6 → wr_ready=0 and the write is dropped. After done, (3,3) reads 2. clr_start held during CLEAR → no restart, done pulses once.
- Assert reset at clear cycle 100 → busy=0, done=0 and rd_valid=0 immediately. Addresses 0..99 read the fill colour; address 100 onward keeps prior data.
- Define FRAME_BUFFER_BOUNDS_CHECK_EN, write (160,0)=7, then read (160,0) → rd_data=0 and (0,1) is unchanged at its prior value.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the frame buffer: default geometry, named colours
// and the clear-engine state encoding.
package frame_buffer_pkg;

  localparam int DEFAULT_WIDTH      = 160;
  localparam int DEFAULT_HEIGHT     = 120;
  localparam int DEFAULT_COLOR_BITS = 3;

  localparam logic [DEFAULT_COLOR_BITS-1:0] COLOR_BLACK      = DEFAULT_COLOR_BITS'(0);
  localparam logic [DEFAULT_COLOR_BITS-1:0] COLOR_BACKGROUND = DEFAULT_COLOR_BITS'(2);

  typedef enum logic [1:0] {
    ClrIdle,
    ClrClear,
    ClrDone
  } clrState_e;

endpackage

// File: rtl/frame_buffer_if.sv
// Pixel bus between the draw/scan-out logic (master) and the frame buffer (slave):
// read port, write port and clear-engine control.
interface frame_buffer_if
  import frame_buffer_pkg::*;
#(
  parameter int XW         = 8,
  parameter int YW         = 7,
  parameter int COLOR_BITS = DEFAULT_COLOR_BITS
);

  logic                  rd_en;
  logic [XW-1:0]         rd_x;
  logic [YW-1:0]         rd_y;
  logic [COLOR_BITS-1:0] rd_data;
  logic                  rd_valid;

  logic                  wr_en;
  logic [XW-1:0]         wr_x;
  logic [YW-1:0]         wr_y;
  logic [COLOR_BITS-1:0] wr_data;
  logic                  wr_ready;

  logic                  clr_start;
  logic [COLOR_BITS-1:0] clr_color;
  logic                  busy;
  logic                  done;

  modport master (
    output rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, clr_start, clr_color,
    input  rd_data, rd_valid, wr_ready, busy, done
  );

  modport slave (
    input  rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, clr_start, clr_color,
    output rd_data, rd_valid, wr_ready, busy, done
  );

endinterface

// File: rtl/fb_ram.sv
// Simple dual-port pixel RAM with a registered, read-first read port.
// Deliberately has no reset so synthesis can map it onto block RAM.
module fb_ram #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// Row-major pixel frame buffer with a full-frame clear engine.
// Optional range checking of coordinates is enabled by FRAME_BUFFER_BOUNDS_CHECK_EN.
module frame_buffer
  import frame_buffer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT,
  parameter int COLOR_BITS = DEFAULT_COLOR_BITS,
  parameter int XW         = 8,
  parameter int YW         = 7
) (
  input logic           clk,
  input logic           reset,
  frame_buffer_if.slave bus
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // All operands are widened to AW before the multiply so y*WIDTH never truncates.
  function automatic logic [AW-1:0] pixelAddr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(WIDTH) + AW'(x);
  endfunction

  clrState_e             state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [COLOR_BITS-1:0] color_q, color_d;
  logic                  rdValid_q, rdOob_q, rdOob_d;

  logic                  wrInRange, rdInRange;
  logic                  clearing, wrReady;
  logic                  ramWe, ramRe;
  logic [AW-1:0]         ramWaddr, rdAddr;
  logic [COLOR_BITS-1:0] ramWdata, ramRdata;

`ifdef FRAME_BUFFER_BOUNDS_CHECK_EN
  assign wrInRange = (int'(bus.wr_x) < WIDTH) && (int'(bus.wr_y) < HEIGHT);
  assign rdInRange = (int'(bus.rd_x) < WIDTH) && (int'(bus.rd_y) < HEIGHT);
`else
  assign wrInRange = 1'b1;
  assign rdInRange = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ClrIdle;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

  // DONE behaves like IDLE for a new start so back-to-back clears lose no cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      ClrIdle, ClrDone: begin
        state_d = ClrIdle;
        if (bus.clr_start) begin
          state_d = ClrClear;
          cnt_d   = '0;
          color_d = bus.clr_color;
        end
      end
      ClrClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ClrDone;
        end
      end
      default: state_d = ClrIdle;
    endcase
  end

  always_comb begin
    clearing     = (state_q == ClrClear);
    wrReady      = !clearing;
    bus.busy     = clearing;
    bus.done     = (state_q == ClrDone);
    bus.wr_ready = wrReady;
    ramWe        = bus.wr_en && wrReady && wrInRange;
    ramWaddr     = pixelAddr(bus.wr_x, bus.wr_y);
    ramWdata     = bus.wr_data;
    if (clearing) begin
      ramWe    = 1'b1;
      ramWaddr = cnt_q;
      ramWdata = color_q;
    end
  end

  assign rdAddr  = pixelAddr(bus.rd_x, bus.rd_y);
  assign ramRe   = bus.rd_en && rdInRange;
  assign rdOob_d = !rdInRange;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdValid_q <= 1'b0;
      rdOob_q   <= 1'b0;
    end else begin
      rdValid_q <= bus.rd_en;
      rdOob_q   <= rdOob_d;
    end
  end

  // The RAM output cannot be reset, so the visible data is forced to black unless valid.
  assign bus.rd_valid = rdValid_q;
  assign bus.rd_data  = (rdValid_q && !rdOob_q) ? ramRdata : COLOR_BITS'(COLOR_BLACK);

  fb_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (COLOR_BITS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ramWe),
    .waddr_i (ramWaddr),
    .wdata_i (ramWdata),
    .re_i    (ramRe),
    .raddr_i (rdAddr),
    .rdata_o (ramRdata)
  );

endmodule

// File: tb/tb_frame_buffer.sv
// Directed testbench for frame_buffer: read/write timing, clear engine,
// reset during a clear and, when enabled, coordinate range checking.
module tb_frame_buffer;
  import frame_buffer_pkg::*;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  frame_buffer_if #(.XW(8), .YW(7), .COLOR_BITS(3)) bus ();

  frame_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdEn, input logic [7:0] rdX, input logic [6:0] rdY,
                               input logic wrEn, input logic [7:0] wrX, input logic [6:0] wrY,
                               input logic [2:0] wrData);
    bus.rd_en   = rdEn;
    bus.rd_x    = rdX;
    bus.rd_y    = rdY;
    bus.wr_en   = wrEn;
    bus.wr_x    = wrX;
    bus.wr_y    = wrY;
    bus.wr_data = wrData;
  endtask

  // Tasks below start and end on a falling edge.
  task automatic writePixel(input logic [7:0] x, input logic [6:0] y, input logic [2:0] d);
    applyStimulus(1'b0, 8'd0, 7'd0, 1'b1, x, y, d);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 7'd0, 1'b0, 8'd0, 7'd0, 3'd0);
  endtask

  task automatic readPixel(input logic [7:0] x, input logic [6:0] y, input logic [2:0] expected, input string tag);
    applyStimulus(1'b1, x, y, 1'b0, 8'd0, 7'd0, 3'd0);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 7'd0, 1'b0, 8'd0, 7'd0, 3'd0);
    checkOutput({tag, "Valid"}, bus.rd_valid, 1);
    checkOutput(tag, bus.rd_data, expected);
  endtask

  task automatic runClear(input logic [2:0] color, input bit holdStart, input bit special);
    int busyCnt = 0;
    int doneCnt = 0;
    bus.clr_start = 1'b1;
    bus.clr_color = color;
    if (special) applyStimulus(1'b0, 8'd0, 7'd0, 1'b1, 8'd20, 7'd20, 3'd5);
    for (int i = 0; i < 19210; i++) begin
      @(negedge clk);
      if (i == 0) applyStimulus(1'b0, 8'd0, 7'd0, 1'b0, 8'd0, 7'd0, 3'd0);
      if (!holdStart || i == 50) bus.clr_start = 1'b0;
      if (bus.busy) busyCnt++;
      if (bus.done) doneCnt++;
      if (special) begin
        if (i == 0) applyStimulus(1'b1, 8'd20, 7'd20, 1'b0, 8'd0, 7'd0, 3'd0);
        if (i == 1) begin
          applyStimulus(1'b0, 8'd0, 7'd0, 1'b0, 8'd0, 7'd0, 3'd0);
          checkOutput("busyReadValid", bus.rd_valid, 1);
          checkOutput("busyReadData", bus.rd_data, 5);
        end
        if (i == 1000) begin
          checkOutput("wrReadyBusy", bus.wr_ready, 0);
          applyStimulus(1'b0, 8'd0, 7'd0, 1'b1, 8'd3, 7'd3, 3'd6);
        end
        if (i == 1001) applyStimulus(1'b0, 8'd0, 7'd0, 1'b0, 8'd0, 7'd0, 3'd0);
      end
    end
    checkOutput("busyCycles", busyCnt, 19200);
    checkOutput("donePulses", doneCnt, 1);
    checkOutput("wrReadyIdle", bus.wr_ready, 1);
  endtask

  initial begin
    int doneCnt;
    logic [7:0] rx;
    logic [6:0] ry;

    reset = 1'b1;
    applyStimulus(1'b0, 8'd0, 7'd0, 1'b0, 8'd0, 7'd0, 3'd0);
    bus.clr_start = 1'b0;
    bus.clr_color = 3'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("resetRdData", bus.rd_data, 0);
    checkOutput("resetRdValid", bus.rd_valid, 0);
    checkOutput("resetBusy", bus.busy, 0);
    checkOutput("resetDone", bus.done, 0);
    checkOutput("resetWrReady", bus.wr_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // Black frame first, holding clr_start well into the clear.
    runClear(3'd0, 1'b1, 1'b0);

    writePixel(8'd10, 7'd5, 3'd5);
    readPixel(8'd10, 7'd5, 3'd5, "read10_5");
    @(negedge clk);
    checkOutput("rdValidLow", bus.rd_valid, 0);
    readPixel(8'd0, 7'd0, 3'd0, "read0_0");
    writePixel(8'd159, 7'd119, 3'd7);
    readPixel(8'd159, 7'd119, 3'd7, "readLastPixel");
    readPixel(8'd0, 7'd1, 3'd0, "read0_1");

    applyStimulus(1'b1, 8'd10, 7'd5, 1'b1, 8'd10, 7'd5, 3'd3);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 7'd0, 1'b0, 8'd0, 7'd0, 3'd0);
    checkOutput("readFirstOld", bus.rd_data, 5);
    readPixel(8'd10, 7'd5, 3'd3, "readAfterWrite");

    runClear(COLOR_BACKGROUND, 1'b0, 1'b1);
    readPixel(8'd0, 7'd0, 3'd2, "cornerTL");
    readPixel(8'd159, 7'd0, 3'd2, "cornerTR");
    readPixel(8'd0, 7'd119, 3'd2, "cornerBL");
    readPixel(8'd159, 7'd119, 3'd2, "cornerBR");
    readPixel(8'd3, 7'd3, 3'd2, "droppedWrite3_3");
    readPixel(8'd20, 7'd20, 3'd2, "overwritten20_20");
    for (int k = 0; k < 8; k++) begin
      rx = 8'($urandom_range(0, 159));
      ry = 7'($urandom_range(0, 119));
      readPixel(rx, ry, 3'd2, "randomSample");
    end

    writePixel(8'd99, 7'd0, 3'd5);
    writePixel(8'd100, 7'd0, 3'd6);
    writePixel(8'd101, 7'd0, 3'd1);
    bus.clr_start = 1'b1;
    bus.clr_color = 3'd4;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) bus.clr_start = 1'b0;
      if (i == 99) applyStimulus(1'b1, 8'd0, 7'd0, 1'b0, 8'd0, 7'd0, 3'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 7'd0, 1'b0, 8'd0, 7'd0, 3'd0);
    checkOutput("preResetValid", bus.rd_valid, 1);
    checkOutput("preResetData", bus.rd_data, 4);
    checkOutput("preResetBusy", bus.busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("midResetBusy", bus.busy, 0);
    checkOutput("midResetDone", bus.done, 0);
    checkOutput("midResetValid", bus.rd_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done) doneCnt++;
    end
    checkOutput("noDoneAfterReset", doneCnt, 0);
    readPixel(8'd0, 7'd0, 3'd4, "partialAddr0");
    readPixel(8'd99, 7'd0, 3'd4, "partialAddr99");
    readPixel(8'd100, 7'd0, 3'd6, "partialAddr100");
    readPixel(8'd101, 7'd0, 3'd1, "partialAddr101");
    readPixel(8'd0, 7'd1, 3'd2, "partialAddr160");

`ifdef FRAME_BUFFER_BOUNDS_CHECK_EN
    writePixel(8'd160, 7'd0, 3'd7);
    readPixel(8'd160, 7'd0, 3'd0, "oobRead");
    readPixel(8'd0, 7'd1, 3'd2, "oobNoAlias");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
